fwd_scoreboard: RTL

Parametrised hazard and forwarding unit for the pipelined MIPS core. It tracks in-flight register writers for NUM_STAGE stages after decode (E, M, W by default) in a registered scoreboard. For each of NUM_RD read channels in D it selects the freshest forwarding source, or falls back to GRF data. It raises a stall when the youngest matching producer's result is not ready by the consumer's Tuse. This single block replaces the per-stage hand-written forwarding muxes and the separate stall logic.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_lookup.sv | 44 ++++
 rtl/fwd_scoreboard.sv | 69 ++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared scoreboard entry type, stage indices and select-width helper for the forwarding unit
package fwd_pkg;
  localparam int ENT_AW = 5;
  localparam int ENT_TW = 2;
  localparam int SEL_GRF = 0;
  typedef enum logic [1:0] {STG_E, STG_M, STG_W} stageIdx;
  typedef struct packed {
    logic v;
    logic [ENT_AW-1:0] addr;
    logic [ENT_TW-1:0] tnew;
  } sbEntry;
  function automatic int selW(input int numStage);
    return $clog2(numStage + 1);
  endfunction
endpackage

// File: rtl/fwd_lookup.sv
// fwd_lookup: per-channel youngest-match lookup giving forward select, operand and stall request
module fwd_lookup import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_STAGE = 3,
  parameter int T_W = 2
) (
  input  logic [NUM_STAGE-1:0]        v,
  input  logic [NUM_STAGE*REG_AW-1:0] addr,
  input  logic [NUM_STAGE*T_W-1:0]    tnew,
  input  logic [REG_AW-1:0]           rdAddr,
  input  logic [T_W-1:0]              rdTuse,
  input  logic [DATA_W-1:0]           grfData,
  input  logic [NUM_STAGE*DATA_W-1:0] stageData,
  output logic [selW(NUM_STAGE)-1:0]  sel,
  output logic [DATA_W-1:0]           data,
  output logic                        stallReq
);
  localparam int SEL_W = selW(NUM_STAGE);
  logic hit;
  logic fwdOk;
  logic [T_W-1:0] hitTnew;
  logic [SEL_W-1:0] hitSel;
  logic [DATA_W-1:0] hitData;
  // Scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    hit = 1'b0;
    hitTnew = '0;
    hitSel = SEL_W'(SEL_GRF);
    hitData = grfData;
    for (int s = NUM_STAGE - 1; s >= 0; s--) begin
      if (v[s] && addr[s*REG_AW +: REG_AW] == rdAddr) begin
        hit = 1'b1;
        hitTnew = tnew[s*T_W +: T_W];
        hitSel = SEL_W'(s + 1);
        hitData = stageData[s*DATA_W +: DATA_W];
      end
    end
  end
  assign fwdOk = hit && rdAddr != '0 && hitTnew == '0;
  assign sel = fwdOk ? hitSel : SEL_W'(SEL_GRF);
  assign data = fwdOk ? hitData : grfData;
  assign stallReq = hit && rdAddr != '0 && hitTnew > rdTuse;
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: registered writer scoreboard with per-channel forwarding and stall; FWD_STALL_CNT_EN adds stall_cnt
// Entry field widths come from fwd_pkg, so REG_AW/T_W track ENT_AW/ENT_TW.
module fwd_scoreboard import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = ENT_AW,
  parameter int NUM_RD = 2,
  parameter int NUM_STAGE = 3,
  parameter int T_W = ENT_TW
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               iss_we,
  input  logic [REG_AW-1:0]                  iss_addr,
  input  logic [T_W-1:0]                     iss_tnew,
  input  logic                               flush,
  input  logic [NUM_RD*REG_AW-1:0]           rd_addr,
  input  logic [NUM_RD*T_W-1:0]              rd_tuse,
  input  logic [NUM_RD*DATA_W-1:0]           grf_data,
  input  logic [NUM_STAGE*DATA_W-1:0]        stage_data,
  output logic [NUM_RD*selW(NUM_STAGE)-1:0]  fwd_sel,
  output logic [NUM_RD*DATA_W-1:0]           fwd_data,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]                        stall_cnt,
`endif
  output logic                               stall
);
  localparam int SEL_W = selW(NUM_STAGE);
  sbEntry sb [NUM_STAGE];
  logic [NUM_STAGE-1:0] vVec;
  logic [NUM_STAGE*REG_AW-1:0] addrVec;
  logic [NUM_STAGE*T_W-1:0] tnewVec;
  logic [NUM_RD-1:0] reqVec;
  for (genvar s = 0; s < NUM_STAGE; s++) begin : gFlat
    assign vVec[s] = sb[s].v;
    assign addrVec[s*REG_AW +: REG_AW] = sb[s].addr;
    assign tnewVec[s*T_W +: T_W] = sb[s].tnew;
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : gRd
    fwd_lookup #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_STAGE(NUM_STAGE), .T_W(T_W)) uLookup (
      .v(vVec),
      .addr(addrVec),
      .tnew(tnewVec),
      .rdAddr(rd_addr[p*REG_AW +: REG_AW]),
      .rdTuse(rd_tuse[p*T_W +: T_W]),
      .grfData(grf_data[p*DATA_W +: DATA_W]),
      .stageData(stage_data),
      .sel(fwd_sel[p*SEL_W +: SEL_W]),
      .data(fwd_data[p*DATA_W +: DATA_W]),
      .stallReq(reqVec[p])
    );
  end
  assign stall = |reqVec;
  // A stalled D instruction must not enter E; flush and stall collapse to one bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STAGE; s++) sb[s] <= '0;
    end else begin
      sb[0] <= (flush || stall) ? '0 : '{v: iss_we && iss_addr != '0, addr: iss_addr, tnew: iss_tnew};
      for (int s = 1; s < NUM_STAGE; s++)
        sb[s] <= '{v: sb[s-1].v, addr: sb[s-1].addr, tnew: sb[s-1].tnew - T_W'(sb[s-1].tnew != '0)};
    end
  end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
